// File: rtl/stream_scan_pkg.sv
// Shared types and default constants for the stream scan controller and its
// bit-serial pattern-match core.
package stream_scan_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int          DEF_WORD_W  = 8;
   localparam int          DEF_PAT_LEN = 5;
   localparam int          DEF_CNT_W   = 8;
   // Right-aligned; the core takes the low PAT_LEN bits, MSB first in time.
   localparam logic [15:0] DEF_PATTERN = 16'b0000_0000_0001_1010;

endpackage

// File: rtl/pattern_match_core.sv
// Bit-serial pattern detector: history shift register, saturating fill count
// and a registered match pulse one cycle after the completing bit.
module pattern_match_core
   import stream_scan_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0]
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_valid,
   input  logic bit_in,
   output logic match_pulse
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] history_r;
   logic [FILL_W-1:0]  fill_r;
   logic               match_r;
   logic [PAT_LEN:0]   shifted_s;
   logic [PAT_LEN-1:0] history_next_s;
   logic [FILL_W-1:0]  fill_next_s;

   // Candidate history and fill count including the bit on bit_in.
   always_comb begin
      shifted_s      = {history_r, bit_in};
      history_next_s = shifted_s[PAT_LEN-1:0];
      if (fill_r == FILL_FULL) begin
         fill_next_s = fill_r;
      end else begin
         fill_next_s = fill_r + FILL_W'(1);
      end
   end

   // History persists across words and idle gaps; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         history_r <= {PAT_LEN{1'b0}};
         fill_r    <= {FILL_W{1'b0}};
         match_r   <= 1'b0;
      end else if (bit_valid) begin
         history_r <= history_next_s;
         fill_r    <= fill_next_s;
         match_r   <= (history_next_s == PATTERN) && (fill_next_s == FILL_FULL);
      end else begin
         match_r   <= 1'b0;
      end
   end

   assign match_pulse = match_r;

endmodule

// File: rtl/stream_scan_ctrl.sv
// Word-to-bit serializer feeding pattern_match_core, with a saturating match
// counter and a sticky threshold interrupt.
module stream_scan_ctrl
   import stream_scan_pkg::*;
#(
   parameter int                 WORD_W  = DEF_WORD_W,
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
   parameter int                 CNT_W   = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   input  logic              clear_cnt,
   input  logic [CNT_W-1:0]  threshold,
   output logic              match_pulse,
   output logic [CNT_W-1:0]  match_count,
   output logic              busy,
   output logic              thresh_irq
);

   localparam int                IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   state_e             state_r;
   state_e             state_next_s;
   logic [WORD_W-1:0]  data_r;
   logic [IDX_W-1:0]   bit_idx_r;
   logic               in_ready_s;
   logic               accept_s;
   logic               busy_s;
   logic               bit_s;
   logic               core_pulse_s;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_inc_s;
   logic               irq_r;

   assign accept_s = in_valid && in_ready_s;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: the last bit of a word may overlap the next accept.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = SHIFT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (bit_idx_r != {IDX_W{1'b0}}) begin
               state_next_s = SHIFT;
            end else if (accept_s) begin
               state_next_s = SHIFT;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Outputs decoded from state; ready is withheld during the reset cycle.
   always_comb begin
      busy_s     = 1'b0;
      in_ready_s = 1'b0;
      case (state_r)
         IDLE: begin
            busy_s     = 1'b0;
            in_ready_s = enable && !reset;
         end
         SHIFT: begin
            busy_s     = 1'b1;
            in_ready_s = enable && !reset && (bit_idx_r == {IDX_W{1'b0}});
         end
         default: begin
            busy_s     = 1'b0;
            in_ready_s = 1'b0;
         end
      endcase
      bit_s = data_r[bit_idx_r];
   end

   // Serializer word latch and MSB-first bit index.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r    <= {WORD_W{1'b0}};
         bit_idx_r <= {IDX_W{1'b0}};
      end else if (accept_s) begin
         data_r    <= in_data;
         bit_idx_r <= LAST_IDX;
      end else if (busy_s && (bit_idx_r != {IDX_W{1'b0}})) begin
         bit_idx_r <= bit_idx_r - IDX_W'(1);
      end
   end

   pattern_match_core #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .bit_valid   (busy_s),
      .bit_in      (bit_s),
      .match_pulse (core_pulse_s)
   );

   assign count_inc_s = (count_r == CNT_MAX) ? count_r : (count_r + CNT_W'(1));

   // Match counter and sticky irq; clear beats a coincident match.
   always_ff @(posedge clk) begin
      if (reset || clear_cnt) begin
         count_r <= {CNT_W{1'b0}};
         irq_r   <= 1'b0;
      end else if (core_pulse_s) begin
         count_r <= count_inc_s;
         if ((threshold != {CNT_W{1'b0}}) && (count_inc_s == threshold)) begin
            irq_r <= 1'b1;
         end
      end
   end

   assign in_ready    = in_ready_s;
   assign busy        = busy_s;
   assign match_pulse = core_pulse_s;
   assign match_count = count_r;
   assign thresh_irq  = irq_r;

endmodule

// File: tb/tb_stream_scan_ctrl.sv
// Randomized self-checking bench for stream_scan_ctrl against a bit-stream
// reference model kept as a queue of shifted bits.
module tb_stream_scan_ctrl;

   localparam int WORD_W  = 8;
   localparam int PAT_LEN = 5;
   localparam int CNT_W   = 8;
   localparam int PAT_VAL = 26;
   localparam int CNT_MAX = 255;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic              clear_cnt;
   logic [CNT_W-1:0]  threshold;
   logic              match_pulse;
   logic [CNT_W-1:0]  match_count;
   logic              busy;
   logic              thresh_irq;

   always #5 clk = ~clk;

   stream_scan_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .clear_cnt   (clear_cnt),
      .threshold   (threshold),
      .match_pulse (match_pulse),
      .match_count (match_count),
      .busy        (busy),
      .thresh_irq  (thresh_irq)
   );

   int err_cnt = 0;
   int chk_cnt = 0;

   // Reference model state.
   int          m_rem   = 0;
   logic [7:0]  m_word  = 8'h00;
   int          m_bits[$];
   bit          m_pulse = 1'b0;
   int          m_count = 0;
   bit          m_irq   = 1'b0;
   bit          m_valid = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit en, input bit v, input logic [7:0] d,
                        input bit clr, input logic [7:0] thr);
      bit acc;
      bit new_pulse;
      int val;
      reset     = r;
      enable    = en;
      in_valid  = v;
      in_data   = d;
      clear_cnt = clr;
      threshold = thr;
      @(negedge clk);
      if (m_valid) begin
         check_val("in_ready", {31'd0, in_ready}, {31'd0, (en && !r && (m_rem <= 1))});
         check_val("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
         check_val("match_pulse", {31'd0, match_pulse}, {31'd0, m_pulse});
         check_val("match_count", {24'd0, match_count}, m_count);
         check_val("thresh_irq", {31'd0, thresh_irq}, {31'd0, m_irq});
      end
      if (r) begin
         m_valid = 1'b1;
         m_rem   = 0;
         m_bits.delete();
         m_pulse = 1'b0;
         m_count = 0;
         m_irq   = 1'b0;
      end else begin
         acc       = v && en && (m_rem <= 1);
         new_pulse = 1'b0;
         if (m_rem > 0) begin
            m_bits.push_back(int'(m_word[m_rem-1]));
            if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
            if (m_bits.size() == PAT_LEN) begin
               val = 0;
               foreach (m_bits[i]) val = val * 2 + m_bits[i];
               new_pulse = (val == PAT_VAL);
            end
            m_rem--;
         end
         if (acc) begin
            m_word = d;
            m_rem  = WORD_W;
         end
         if (clr) begin
            m_count = 0;
            m_irq   = 1'b0;
         end else if (m_pulse) begin
            if (m_count < CNT_MAX) m_count++;
            if ((thr != 8'd0) && (m_count == int'(thr))) m_irq = 1'b1;
         end
         m_pulse = new_pulse;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] thr_v;
      logic [7:0] d_v;
      int         sel;
      thr_v = 8'd0;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
      cycle(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'd0);

      // Single word with the pattern at its head.
      cycle(1'b0, 1'b1, 1'b1, 8'hD0, 1'b0, 8'd0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
      check_val("d0_count", {24'd0, match_count}, 32'd1);

      // Back-to-back words with the pattern spanning the boundary.
      cycle(1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 8'd0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
      check_val("span_count", {24'd0, match_count}, 32'd2);

      // Pattern at the tail of the first word after reset.
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
      cycle(1'b0, 1'b1, 1'b1, 8'h1A, 1'b0, 8'd0);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
      check_val("tail_count", {24'd0, match_count}, 32'd1);

      // Random traffic: resets, enable drops, clears and threshold changes.
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0:       d_v = 8'hD0;
            1:       d_v = 8'h1A;
            2:       d_v = 8'h06;
            3:       d_v = 8'h80;
            4:       d_v = 8'hDA;
            default: d_v = 8'($urandom);
         endcase
         if ($urandom_range(0, 49) == 0) thr_v = 8'($urandom_range(0, 6));
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 9) < 7), d_v, ($urandom_range(0, 59) == 0), thr_v);
      end

      // Continuous matching stream drives the counter into saturation.
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd200);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd200);
      for (int i = 0; i < 2600; i++) cycle(1'b0, 1'b1, 1'b1, 8'hDA, 1'b0, 8'd200);
      check_val("sat_count", {24'd0, match_count}, 32'd255);
      check_val("sat_irq", {31'd0, thresh_irq}, 32'd1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
